// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline sequencer: multicycle FSM states,
// default stage indices and the countdown width helper.
package pipeline_sequencer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } multi_state_e;

   localparam int FETCH  = 0;
   localparam int DECODE = 1;
   localparam int EXEC   = 2;
   localparam int MEM    = 3;
   localparam int WB     = 4;

   function automatic int cnt_width(input int latency);
      return $clog2(latency);
   endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Hazard inputs and per-stage control outputs of the pipeline sequencer.
// The sequencer side uses the master modport, the datapath side the slave.
interface pipeline_sequencer_if #(
   parameter int STAGES = 5
);
   logic              ext_stall;
   logic              multi_start;
   logic              branch_taken;
   logic              load_use;
   logic [STAGES-1:0] enable;
   logic [STAGES-1:0] flush;
   logic [STAGES-1:0] valid;
   logic              busy;
   logic              multi_done;

   modport master (
      input  ext_stall, multi_start, branch_taken, load_use,
      output enable, flush, valid, busy, multi_done
   );

   modport slave (
      output ext_stall, multi_start, branch_taken, load_use,
      input  enable, flush, valid, busy, multi_done
   );
endinterface

// File: rtl/pipeline_sequencer_multi.sv
// IDLE/BUSY hold FSM for multicycle ops in the execute stage. The start cycle
// plus MULTI_LATENCY-1 busy cycles keep the op in place; stalls freeze it.
module pipeline_sequencer_multi
   import pipeline_sequencer_pkg::*;
#(
   parameter int MULTI_LATENCY = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic stall,
   input  logic start,
   output logic busy,
   output logic multi_done
);
   localparam int CW = cnt_width(MULTI_LATENCY);
   localparam logic [CW-1:0] LOAD_VAL = CW'(MULTI_LATENCY - 2);

   multi_state_e  state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      multi_done = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && !stall) begin
               state_next = BUSY;
               cnt_next   = LOAD_VAL;
            end
         end
         BUSY: begin
            // The done pulse persists through stalls; only a live cycle retires the op.
            if (cnt_reg == '0) begin
               multi_done = 1'b1;
               if (!stall) begin
                  state_next = IDLE;
               end
            end else if (!stall) begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state_reg == BUSY);

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the pipelined datapath: prioritised hazard decode
// and per-stage valid tracking. Define PIPELINE_SEQUENCER_LOAD_USE_EN to honour load_use.
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int STAGES        = 5,
   parameter int HAZ_STAGE     = DECODE,
   parameter int EXEC_STAGE    = EXEC,
   parameter int MULTI_LATENCY = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   pipeline_sequencer_if.master      bus
);
   logic [STAGES-1:0] stage_enable;
   logic [STAGES-1:0] stage_flush;
   logic [STAGES-1:0] valid_reg, valid_next;
   logic [STAGES-1:0] hold_exec_mask, exec_bubble_mask;
   logic [STAGES-1:0] hold_haz_mask, haz_bubble_mask;
   logic [STAGES-1:0] wrong_path_mask;
   logic              busy;
   logic              multi_done;
   logic              load_use_act;

`ifdef PIPELINE_SEQUENCER_LOAD_USE_EN
   assign load_use_act = bus.load_use;
`else
   wire unused_load_use = bus.load_use;
   assign load_use_act = 1'b0;
`endif

   pipeline_sequencer_multi #(
      .MULTI_LATENCY (MULTI_LATENCY)
   ) u_multi (
      .clk        (clk),
      .rst        (rst),
      .stall      (bus.ext_stall),
      .start      (bus.multi_start),
      .busy       (busy),
      .multi_done (multi_done)
   );

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_mask
         assign hold_exec_mask[gi]   = (gi <= EXEC_STAGE);
         assign exec_bubble_mask[gi] = (gi == EXEC_STAGE + 1);
         assign hold_haz_mask[gi]    = (gi <= HAZ_STAGE);
         assign haz_bubble_mask[gi]  = (gi == HAZ_STAGE + 1);
         assign wrong_path_mask[gi]  = (gi >= 1) && (gi <= EXEC_STAGE);
      end
   endgenerate

   always_comb begin
      stage_enable = '1;
      stage_flush  = '0;
      if (rst) begin
         stage_enable = '0;
         stage_flush  = '1;
      end else if (bus.ext_stall) begin
         stage_enable = '0;
      end else if (busy || bus.multi_start) begin
         stage_enable = ~hold_exec_mask;
         stage_flush  = exec_bubble_mask;
      end else if (bus.branch_taken) begin
         // Branch beats load-use: the dependent instruction is on the wrong path.
         stage_flush  = wrong_path_mask;
      end else if (load_use_act) begin
         stage_enable = ~hold_haz_mask;
         stage_flush  = haz_bubble_mask;
      end
   end

   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_valid
         if (gi == 0) begin : g_head
            assign valid_next[gi] = stage_enable[gi] ? ~stage_flush[gi] : valid_reg[gi];
         end else begin : g_body
            assign valid_next[gi] = stage_enable[gi] ? (~stage_flush[gi] & valid_reg[gi-1])
                                                     : valid_reg[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
      end else begin
         valid_reg <= valid_next;
      end
   end

   assign bus.enable     = stage_enable;
   assign bus.flush      = stage_flush;
   assign bus.valid      = valid_reg;
   assign bus.busy       = busy;
   assign bus.multi_done = multi_done;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_pipeline_sequencer;
   import pipeline_sequencer_pkg::*;

   localparam int S  = 5;
   localparam int HZ = 1;
   localparam int EX = 2;
   localparam int ML = 4;
`ifdef PIPELINE_SEQUENCER_LOAD_USE_EN
   localparam bit LU_EN = 1'b1;
`else
   localparam bit LU_EN = 1'b0;
`endif
   localparam logic [S-1:0] ALL0 = '0;
   localparam logic [S-1:0] ALL1 = '1;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [S-1:0] m_valid;
   int           m_rem;

   always #5 clk = ~clk;

   pipeline_sequencer_if #(.STAGES(S)) bus ();

   pipeline_sequencer #(
      .STAGES        (S),
      .HAZ_STAGE     (HZ),
      .EXEC_STAGE    (EX),
      .MULTI_LATENCY (ML)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic drive(input logic st, input logic ms, input logic bt, input logic lu);
      bus.ext_stall    = st;
      bus.multi_start  = ms;
      bus.branch_taken = bt;
      bus.load_use     = lu;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      drive(0, 0, 0, 0);
      repeat (n) tick();
   endtask

   // Expected stage controls straight from the hazard priority rules.
   function automatic void model_ctrl(input logic r, input logic st, input logic ms,
                                      input logic bt, input logic lu, input int rem,
                                      output logic [S-1:0] en, output logic [S-1:0] fl);
      en = '1;
      fl = '0;
      if (r) begin
         en = '0;
         fl = '1;
      end else if (st) begin
         en = '0;
      end else if (rem > 0 || ms) begin
         for (int i = 0; i < S; i++) begin
            en[i] = (i > EX);
            fl[i] = (i == EX + 1);
         end
      end else if (bt) begin
         for (int i = 0; i < S; i++) fl[i] = (i >= 1 && i <= EX);
      end else if (lu && LU_EN) begin
         for (int i = 0; i < S; i++) begin
            en[i] = (i > HZ);
            fl[i] = (i == HZ + 1);
         end
      end
   endfunction

   // m_rem counts busy cycles still to come; the op finishes when it reaches 1.
   task automatic model_step(input logic st, input logic ms, input logic bt, input logic lu);
      logic [S-1:0] en, fl, nv;
      model_ctrl(1'b0, st, ms, bt, lu, m_rem, en, fl);
      for (int i = 0; i < S; i++) begin
         if (!en[i]) nv[i] = m_valid[i];
         else if (fl[i]) nv[i] = 1'b0;
         else if (i == 0) nv[i] = 1'b1;
         else nv[i] = m_valid[i-1];
      end
      m_valid = nv;
      if (!st) begin
         if (m_rem > 0) m_rem = m_rem - 1;
         else if (ms) m_rem = ML - 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (bus.enable !== ALL0) begin
            errors++; $display("FAIL reset_enable cycle %0d got %b want %b", c, bus.enable, ALL0);
         end
         checks++;
         if (bus.flush !== ALL1) begin
            errors++; $display("FAIL reset_flush cycle %0d got %b want %b", c, bus.flush, ALL1);
         end
         checks++;
         if (bus.valid !== ALL0 || bus.busy !== 1'b0 || bus.multi_done !== 1'b0) begin
            errors++; $display("FAIL reset_state cycle %0d got valid=%b busy=%b done=%b want 00000/0/0",
                               c, bus.valid, bus.busy, bus.multi_done);
         end
         tick();
      end
      rst = 1'b0;
      $display("test_reset: 4 reset cycles checked");
   endtask

   task automatic test_fill();
      logic [S-1:0] want;
      drive(0, 0, 0, 0);
      for (int k = 0; k <= S; k++) begin
         #1;
         want = S'((1 << k) - 1);
         checks++;
         if (bus.valid !== want) begin
            errors++; $display("FAIL fill_valid step %0d got %b want %b", k, bus.valid, want);
         end
         tick();
      end
      $display("test_fill: valid filled over %0d cycles", S);
   endtask

   task automatic test_load_use();
      logic [S-1:0] want_en, want_fl, want_v;
      idle_cycles(S);
      drive(0, 0, 0, 1);
      #1;
      want_en = LU_EN ? 5'b11100 : 5'b11111;
      want_fl = LU_EN ? 5'b00100 : 5'b00000;
      want_v  = LU_EN ? 5'b11011 : 5'b11111;
      checks++;
      if (bus.enable !== want_en || bus.flush !== want_fl) begin
         errors++; $display("FAIL load_use_ctrl got en=%b fl=%b want en=%b fl=%b",
                            bus.enable, bus.flush, want_en, want_fl);
      end
      tick();
      drive(0, 0, 0, 0);
      #1;
      checks++;
      if (bus.valid !== want_v) begin
         errors++; $display("FAIL load_use_valid got %b want %b", bus.valid, want_v);
      end
      $display("test_load_use: load_use_en=%0d en=%b", LU_EN, want_en);
   endtask

   task automatic test_branch_load();
      idle_cycles(S);
      drive(0, 0, 1, 1);
      #1;
      checks++;
      if (bus.enable !== 5'b11111 || bus.flush !== 5'b00110) begin
         errors++; $display("FAIL branch_ctrl got en=%b fl=%b want en=11111 fl=00110",
                            bus.enable, bus.flush);
      end
      tick();
      drive(0, 0, 0, 0);
      #1;
      checks++;
      if (bus.valid !== 5'b11001) begin
         errors++; $display("FAIL branch_valid got %b want 11001", bus.valid);
      end
      $display("test_branch_load: branch over load_use checked");
   endtask

   task automatic test_multi();
      idle_cycles(S);
      drive(0, 1, 0, 0);
      for (int c = 0; c < ML; c++) begin
         #1;
         checks++;
         if (bus.enable !== 5'b11000 || bus.flush !== 5'b01000) begin
            errors++; $display("FAIL multi_ctrl t+%0d got en=%b fl=%b want en=11000 fl=01000",
                               c, bus.enable, bus.flush);
         end
         checks++;
         if (bus.busy !== (c > 0) || bus.multi_done !== (c == ML - 1)) begin
            errors++; $display("FAIL multi_flags t+%0d got busy=%b done=%b want busy=%0d done=%0d",
                               c, bus.busy, bus.multi_done, (c > 0), (c == ML - 1));
         end
         tick();
         drive(0, 0, 0, 0);
      end
      #1;
      checks++;
      if (bus.enable !== ALL1 || bus.flush !== ALL0 || bus.busy !== 1'b0 || bus.multi_done !== 1'b0) begin
         errors++; $display("FAIL multi_after got en=%b fl=%b busy=%b done=%b want 11111/00000/0/0",
                            bus.enable, bus.flush, bus.busy, bus.multi_done);
      end
      checks++;
      if (bus.valid !== 5'b00111) begin
         errors++; $display("FAIL multi_valid got %b want 00111", bus.valid);
      end
      $display("test_multi: %0d-cycle hold checked", ML);
   endtask

   task automatic test_multi_stall();
      idle_cycles(S);
      drive(0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0);
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL stall_busy got %b want 1", bus.busy);
      end
      tick();
      drive(1, 0, 0, 0);
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (bus.enable !== ALL0 || bus.flush !== ALL0 || bus.multi_done !== 1'b0) begin
            errors++; $display("FAIL stall_ctrl cycle %0d got en=%b fl=%b done=%b want 00000/00000/0",
                               c, bus.enable, bus.flush, bus.multi_done);
         end
         checks++;
         if (bus.valid !== 5'b00111) begin
            errors++; $display("FAIL stall_valid cycle %0d got %b want 00111", c, bus.valid);
         end
         tick();
      end
      drive(0, 0, 0, 0);
      #1;
      checks++;
      if (bus.multi_done !== 1'b0 || bus.enable !== 5'b11000) begin
         errors++; $display("FAIL stall_resume got done=%b en=%b want 0/11000", bus.multi_done, bus.enable);
      end
      tick();
      checks++;
      if (bus.multi_done !== 1'b1 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL stall_done got done=%b busy=%b want 1/1", bus.multi_done, bus.busy);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.enable !== ALL1) begin
         errors++; $display("FAIL stall_after got busy=%b en=%b want 0/11111", bus.busy, bus.enable);
      end
      $display("test_multi_stall: done delayed by 2 stall cycles");
   endtask

   task automatic test_reset_mid_busy();
      idle_cycles(S);
      drive(0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0);
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.valid !== ALL0 || bus.multi_done !== 1'b0) begin
         errors++; $display("FAIL midbusy_reset got busy=%b valid=%b done=%b want 0/00000/0",
                            bus.busy, bus.valid, bus.multi_done);
      end
      checks++;
      if (bus.enable !== ALL0 || bus.flush !== ALL1) begin
         errors++; $display("FAIL midbusy_ctrl got en=%b fl=%b want 00000/11111", bus.enable, bus.flush);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (c == 2) rst = 1'b0;
         #1;
         checks++;
         if (bus.multi_done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL midbusy_pulse cycle %0d got done=%b busy=%b want 0/0",
                               c, bus.multi_done, bus.busy);
         end
      end
      $display("test_reset_mid_busy: busy cleared without done pulse");
   endtask

   task automatic test_random();
      logic         r, st, ms, bt, lu;
      logic [S-1:0] en, fl;
      rst = 1'b1;
      drive(0, 0, 0, 0);
      #1;
      rst = 1'b0;
      m_valid = '0;
      m_rem   = 0;
      for (int n = 0; n < 1500; n++) begin
         r  = ($urandom_range(59) == 0);
         st = ($urandom_range(7) == 0);
         ms = ($urandom_range(6) == 0);
         bt = ($urandom_range(5) == 0);
         lu = ($urandom_range(4) == 0);
         drive(st, ms, bt, lu);
         if (r) begin
            rst = 1'b1;
            m_valid = '0;
            m_rem   = 0;
         end
         #1;
         model_ctrl(r, st, ms, bt, lu, m_rem, en, fl);
         checks++;
         if (bus.enable !== en || bus.flush !== fl) begin
            errors++; $display("FAIL rand_ctrl n=%0d in=%b%b%b%b%b got en=%b fl=%b want en=%b fl=%b",
                               n, r, st, ms, bt, lu, bus.enable, bus.flush, en, fl);
         end
         checks++;
         if (bus.valid !== m_valid) begin
            errors++; $display("FAIL rand_valid n=%0d got %b want %b", n, bus.valid, m_valid);
         end
         checks++;
         if (bus.busy !== (m_rem > 0) || bus.multi_done !== (m_rem == 1)) begin
            errors++; $display("FAIL rand_multi n=%0d got busy=%b done=%b want busy=%0d done=%0d",
                               n, bus.busy, bus.multi_done, (m_rem > 0), (m_rem == 1));
         end
         @(posedge clk);
         if (!r) model_step(st, ms, bt, lu);
         #1;
         rst = 1'b0;
      end
      $display("test_random: 1500 randomized cycles checked");
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0);
      test_reset();
      test_fill();
      test_load_use();
      test_branch_load();
      test_multi();
      test_multi_stall();
      test_reset_mid_busy();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush controller for the pipelined MIPS datapath. It drives per-stage enable and flush for a STAGES-deep chain of pipeline registers built from the team's delay-register blocks, and tracks a valid bit per stage. It resolves four hazard sources in a fixed priority: external memory stall, multicycle-op hold, taken branch, and load-use.

## Interface

Parameters:
- STAGES, 5: number of pipeline registers; index 0 = fetch, STAGES-1 = writeback.
- HAZ_STAGE, 1: stage holding the instruction checked for load-use (ID).
- EXEC_STAGE, 2: stage resolving branches and running multicycle ops (EX); requires 0 < HAZ_STAGE < EXEC_STAGE < STAGES-1.
- MULTI_LATENCY, 4: total cycles a multicycle op occupies EXEC_STAGE; minimum 2.

Ports:
- ctrl  input  bundle  control bundle; `Data_Control_Clock(ctrl)` is the single clock, `Data_Control_Reset(ctrl)` the reset (one clock; reset is asynchronous and active-high).
- ext_stall  input  1  memory wait; freeze entire pipeline.
- multi_start  input  1  instruction in EXEC_STAGE is a multicycle op.
- branch_taken  input  1  branch in EXEC_STAGE resolved taken.
- load_use  input  1  instruction in HAZ_STAGE needs a load result currently in EXEC_STAGE.
- enable  output  STAGES  register i captures its input at the next edge.
- flush  output  STAGES  register i captures a bubble (valid cleared); only meaningful with enable[i]=1.
- valid  output  STAGES  registered valid bit per stage.
- busy  output  1  multicycle hold in progress.
- multi_done  output  1  one-cycle pulse in the final hold cycle.

## Operation

- Default (no hazard): enable all 1, flush all 0.
- Priority per cycle, highest first:
  - reset
  - ext_stall
  - busy or multi_start
  - branch_taken
  - load_use
- ext_stall: enable all 0, flush all 0, counter frozen. Lower-priority inputs are ignored this cycle.
- multi_start while IDLE: FSM enters BUSY, counter loads MULTI_LATENCY-2.
- BUSY or multi_start cycle:
  - enable[0..EXEC_STAGE]=0.
  - enable[EXEC_STAGE+1]=1 with flush[EXEC_STAGE+1]=1, so a bubble goes downstream.
  - Later stages advance.
  - branch_taken and load_use are ignored.
- BUSY counter: decrements each non-stalled cycle. At 0, multi_done=1 and FSM returns to IDLE on the edge. The next cycle is normal, so the op advances out of EXEC_STAGE.
- branch_taken: enable all 1, flush[1..EXEC_STAGE]=1, killing wrong-path instructions. Register 0 loads the redirected fetch. The branch itself advances into EXEC_STAGE+1.
- load_use:
  - enable[0..HAZ_STAGE]=0.
  - enable[HAZ_STAGE+1]=1 with flush[HAZ_STAGE+1]=1.
  - Later stages advance.
  - Lasts exactly the cycle(s) load_use is asserted.
- Simultaneous branch_taken and load_use: branch wins, because the dependent instruction is on the wrong path.
- Valid tracking, on each edge with enable[i]=1:
  - valid[i] <= 0 if flush[i].
  - Otherwise valid[0] <= 1 and valid[i] <= valid[i-1].
  - Registers with enable[i]=0 hold their value.

## Timing

- enable, flush, multi_done: combinational from inputs and registered state, valid in the same cycle.
- valid, busy, FSM, counter: registered, update on the rising clock.
- Reset asserted, asynchronous: valid=0, busy=0, FSM=IDLE, counter=0, enable all 0, flush all 1, multi_done=0.
- After reset release: valid fills one stage per cycle and reaches all ones after STAGES cycles without hazards.
- Multicycle: EXEC_STAGE is held for exactly MULTI_LATENCY cycles (the start cycle plus MULTI_LATENCY-1 BUSY cycles), plus one extra cycle per ext_stall cycle.
- Reset mid-BUSY: FSM returns to IDLE immediately and no multi_done is issued.
- ext_stall during the multi_done cycle: the pulse stays asserted and the FSM stays BUSY until a non-stalled cycle.

## Configuration

- PIPELINE_SEQUENCER_LOAD_USE_EN:
  - Defined: load_use is handled as above.
  - Undefined: the load_use port exists but is ignored, and software schedules load delay slots.
  - All other behaviour is identical either way.

## Structure

- Shared package Data/Pipeline holds:
  - the FSM enum (IDLE, BUSY);
  - default stage index constants (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4);
  - the count-width function $clog2(MULTI_LATENCY).
- One sub-module, pipeline_sequencer_multi: the IDLE/BUSY FSM and countdown, with outputs busy and multi_done. The top-level handles priority decode and the valid chain.

## Test plan

Defaults are STAGES=5, HAZ_STAGE=1, EXEC_STAGE=2, MULTI_LATENCY=4.

- Reset held 4 cycles, then released with no hazards -> during reset enable=00000, flush=11111, valid=00000. After release valid steps 00001, 00011, … 11111 over 5 cycles.
- load_use for 1 cycle with valid=11111 -> that cycle enable=11100 (bits 0,1 low), flush=00100. Next cycle valid[2]=0.
- branch_taken and load_use in the same cycle -> enable=11111, flush=00110. Next cycle valid=11001.
- multi_start at cycle t -> enable=11000 and flush=01000 for cycles t..t+3, multi_done=1 at t+3, busy=1 at t+1..t+3. Normal operation from t+4.
- ext_stall for 2 cycles during BUSY (counter=1) -> enable=00000, counter and valid frozen. multi_done comes 2 cycles later than without the stall.
- Reset asserted mid-BUSY -> busy=0 immediately, valid=00000, no multi_done pulse. With the macro undefined, load_use=1 -> enable=11111.
